// File: rtl/round_key_gen.sv
// round_key_gen: sequential AES-128 key expansion that streams round keys 0..10 over valid/ready
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   key_in/key_valid    cipher key input (byte 0 at [127:120]); accepted only when key_ready
//   key_ready           high in IDLE
//   rk_out/rk_round     current round key and its index 0..10, held while rk_ready is low
//   rk_last             high while round 10 is being presented
//   rk_valid/rk_ready   round-key handshake
//   busy                high while a schedule is being emitted
// Optional macro RK_STORE_EN adds a schedule store:
//   rd_idx              round index to read
//   rd_key              registered read data, 0 for rd_idx > 10
//   store_valid         all 11 entries of the current schedule are written
module round_key_gen (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         rk_valid,
    input  logic         rk_ready,
`ifdef RK_STORE_EN
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         store_valid,
`endif
    output logic         busy
);
    typedef enum logic {IDLE, EMIT} state_t;

    // AES S-box, entry 0 in the top byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // byte b lives at bits 8*(255-b)+7 downto 8*(255-b), i.e. index {~b, 3'b111}
    function automatic logic [7:0] sub(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t state, state_nx;
    logic accept, hs, at_last;
    logic [3:0] nxt_round;
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

    assign accept    = key_valid & key_ready;
    assign hs        = rk_valid & rk_ready;
    assign at_last   = rk_round == 4'd10;
    assign nxt_round = rk_round + 4'd1;

    // one combinational step from the registered key: SubWord(RotWord(w3)) ^ Rcon, then XOR chain
    assign {w0, w1, w2, w3} = rk_out;
    assign t  = {sub(w3[23:16]) ^ rcon(nxt_round), sub(w3[15:8]), sub(w3[7:0]), sub(w3[31:24])};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx  = state;
        key_ready = state == IDLE;
        rk_valid  = state == EMIT;
        busy      = state == EMIT;
        rk_last   = rk_valid && at_last;
        if (accept)
            state_nx = EMIT;
        else if (hs && at_last)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rk_out   <= '0;
            rk_round <= '0;
        end else if (accept) begin
            rk_out   <= key_in;
            rk_round <= '0;
        end else if (hs && !at_last) begin
            rk_out   <= {n0, n1, n2, n3};
            rk_round <= nxt_round;
        end

`ifdef RK_STORE_EN
    logic [127:0] store [11];

    always_ff @(posedge clk)
        if (hs)
            store[rk_round] <= rk_out;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_key      <= '0;
            store_valid <= 1'b0;
        end else begin
            rd_key <= (rd_idx <= 4'd10) ? store[rd_idx] : '0;
            if (accept)
                store_valid <= 1'b0;
            else if (hs && at_last)
                store_valid <= 1'b1;
        end
`endif
endmodule

// File: tb/tb_round_key_gen.sv
// tb_round_key_gen: randomized self-checking bench for round_key_gen against a FIPS-style word-recurrence model
module tb_round_key_gen;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic         busy;
`ifdef RK_STORE_EN
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_key;
    logic         store_valid;
`endif

    int vectors = 0;
    int errors = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] exp_k [11];
    logic [127:0] obs [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    round_key_gen dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .rk_out(rk_out), .rk_round(rk_round), .rk_last(rk_last), .rk_valid(rk_valid),
        .rk_ready(rk_ready),
`ifdef RK_STORE_EN
        .rd_idx(rd_idx), .rd_key(rd_key), .store_valid(store_valid),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = '0;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // w[i] = w[i-4] ^ f(w[i-1]) over 44 words, Rcon generated by repeated doubling
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Accepts key at the next edge (block must be idle), then follows the schedule to the idle cycle.
    task automatic run_sched(input logic [127:0] key, input bit stall, input bit inject);
        int r, cyc;
        model_expand(key);
        vectors++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_accept key_ready got %b want 1", key_ready);
        end
        key_in = key;
        key_valid = 1'b1;
        rk_ready = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b0;
        r = 0;
        cyc = 0;
        while (r <= 10 && cyc < 300) begin
            vectors++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || key_ready !== 1'b0 || rk_round !== 4'(r)
                || rk_out !== exp_k[r] || rk_last !== (r == 10)) begin
                errors++;
                $display("FAIL emit r=%0d got v=%b b=%b kr=%b rnd=%0d last=%b key=%h want key=%h",
                         r, rk_valid, busy, key_ready, rk_round, rk_last, rk_out, exp_k[r]);
            end
`ifdef RK_STORE_EN
            vectors++;
            if (store_valid !== 1'b0) begin
                errors++;
                $display("FAIL store_valid_busy r=%0d got %b want 0", r, store_valid);
            end
`endif
            obs[r] = rk_out;
            rk_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (inject && r == 5) begin
                key_valid = 1'b1;
                key_in = key ^ {rand128()} ^ 128'h1;
            end else
                key_valid = 1'b0;
            @(posedge clk); #1;
            if (rk_ready) r++;
            cyc++;
        end
        rk_ready = 1'b0;
        key_valid = 1'b0;
        vectors++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL sched_timeout got round %0d want 11 handshakes", r);
        end
        vectors++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || rk_last !== 1'b0
            || rk_out !== exp_k[10]) begin
            errors++;
            $display("FAIL post_sched got v=%b kr=%b b=%b last=%b key=%h want 0 1 0 0 key=%h",
                     rk_valid, key_ready, busy, rk_last, rk_out, exp_k[10]);
        end
`ifdef RK_STORE_EN
        vectors++;
        if (store_valid !== 1'b1) begin
            errors++;
            $display("FAIL store_valid_end got %b want 1", store_valid);
        end
`endif
        if (!stall) begin
            vectors++;
            if (cyc != 11) begin
                errors++;
                $display("FAIL emit_cycles got %0d want 11", cyc);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== '0 || rk_round !== '0
            || rk_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset got kr=%b v=%b key=%h rnd=%0d last=%b b=%b want 1 0 0 0 0 0",
                     key_ready, rk_valid, rk_out, rk_round, rk_last, busy);
        end
`ifdef RK_STORE_EN
        vectors++;
        if (store_valid !== 1'b0 || rd_key !== '0) begin
            errors++;
            $display("FAIL reset_store got sv=%b rd=%h want 0 0", store_valid, rd_key);
        end
`endif
    endtask

    task automatic test_fips();
        run_sched(FIPS_KEY, 1'b0, 1'b0);
        vectors += 4;
        if (obs[0] !== FIPS_KEY) begin
            errors++;
            $display("FAIL fips_r0 got %h want %h", obs[0], FIPS_KEY);
        end
        if (obs[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL fips_r1 got %h want a0fafe1788542cb123a339392a6c7605", obs[1]);
        end
        if (obs[2] !== 128'hf2c295f27a96b9435935807a7359f67f) begin
            errors++;
            $display("FAIL fips_r2 got %h want f2c295f27a96b9435935807a7359f67f", obs[2]);
        end
        if (obs[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL fips_r10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", obs[10]);
        end
    endtask

`ifdef RK_STORE_EN
    task automatic test_store();
        rd_idx = 4'd10;
        @(posedge clk); #1;
        vectors++;
        if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL store_rd10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rd_key);
        end
        for (int i = 0; i < 11; i++) begin
            rd_idx = 4'(i);
            @(posedge clk); #1;
            vectors++;
            if (rd_key !== exp_k[i]) begin
                errors++;
                $display("FAIL store_rd idx=%0d got %h want %h", i, rd_key, exp_k[i]);
            end
        end
        for (int i = 11; i < 16; i++) begin
            rd_idx = 4'(i);
            @(posedge clk); #1;
            vectors++;
            if (rd_key !== '0) begin
                errors++;
                $display("FAIL store_rd_oob idx=%0d got %h want 0", i, rd_key);
            end
        end
        rd_idx = '0;
    endtask
`endif

    task automatic test_zero_key();
        run_sched('0, 1'b0, 1'b0);
        vectors++;
        if (obs[1] !== 128'h62636363626363636263636362636363) begin
            errors++;
            $display("FAIL zero_r1 got %h want 62636363626363636263636362636363", obs[1]);
        end
    endtask

    task automatic test_stall();
        run_sched(FIPS_KEY, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) run_sched(rand128(), 1'b1, 1'b0);
    endtask

    task automatic test_ignore_key();
        run_sched(FIPS_KEY, 1'b0, 1'b1);
        run_sched(rand128(), 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) run_sched(rand128(), 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        int cnt;
        key_in = rand128();
        key_valid = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        cnt = 0;
        while (rk_round !== 4'd4 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        vectors++;
        if (cnt >= 20) begin
            errors++;
            $display("FAIL mid_reset_wait got round %0d want 4", rk_round);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== '0 || rk_round !== '0
            || rk_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got kr=%b v=%b key=%h rnd=%0d last=%b b=%b want 1 0 0 0 0 0",
                     key_ready, rk_valid, rk_out, rk_round, rk_last, busy);
        end
`ifdef RK_STORE_EN
        vectors++;
        if (store_valid !== 1'b0 || rd_key !== '0) begin
            errors++;
            $display("FAIL mid_reset_store got sv=%b rd=%h want 0 0", store_valid, rd_key);
        end
`endif
        rk_ready = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle got v=%b kr=%b want 0 1", rk_valid, key_ready);
        end
        run_sched(rand128(), 1'b0, 1'b0);
    endtask

    initial begin
        build_sbox();
        repeat (2) @(posedge clk);
        test_reset();
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        test_fips();
`ifdef RK_STORE_EN
        test_store();
`endif
        test_zero_key();
        test_stall();
        test_ignore_key();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
